// File: rtl/decoder_mul_pkg.sv
// Shared width and bound helpers for the decoder arithmetic blocks.
package decoder_mul_pkg;

  // Width of the exact signed product of two operands, each extended by one bit.
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 2;
  endfunction

  // Working width for round/shift/compare: one bit of headroom over the
  // product for the rounding add, and never narrower than the result plus sign.
  function automatic int res_width(input int p, input int dw);
    return ((p + 1) > (dw + 1)) ? (p + 1) : (dw + 1);
  endfunction

  // Largest value representable in a dw-bit two's complement result.
  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a dw-bit two's complement result.
  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/decoder_mul_rndsat.sv
// Combinational round / arithmetic shift / saturate stage for the multiplier.
module decoder_mul_rndsat
  import decoder_mul_pkg::*;
#(
  parameter int P          = 37,
  parameter int SHIFT      = 8,
  parameter int ROUND      = 1,
  parameter int SAT        = 1,
  parameter int dout_WIDTH = 26
) (
  input  logic signed [P-1:0]          prod,
  output logic        [dout_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int RW     = res_width(P, dout_WIDTH);
  localparam int RND_SH = (SHIFT > 0) ? (SHIFT - 1) : 0;
  // Half an output LSB, added before the shift for round-half-up.
  localparam logic signed [RW-1:0] RND_ADD =
    ((ROUND != 0) && (SHIFT > 0)) ? (RW'(1) << RND_SH) : '0;
  localparam logic signed [RW-1:0] MAX_V = RW'(sat_max(dout_WIDTH));
  localparam logic signed [RW-1:0] MIN_V = RW'(sat_min(dout_WIDTH));

  logic signed [RW-1:0] ext;
  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] r;

  // Extend, round, shift, then range-check and clamp or wrap.
  always_comb begin
    ext = {{(RW - P){prod[P-1]}}, prod};
    rnd = ext + RND_ADD;
    r   = rnd >>> SHIFT;
    ovf = (r > MAX_V) || (r < MIN_V);
    if ((SAT != 0) && ovf) begin
      dout = r[RW-1] ? MIN_V[dout_WIDTH-1:0] : MAX_V[dout_WIDTH-1:0];
    end else begin
      dout = r[dout_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/decoder_mul_pipe.sv
// Pipelined fixed-point multiplier with rounding, shift and saturation.
// Handshake: in_vld qualifies din0/din1 on any ce=1 edge; there is no
// backpressure, so out_vld marks dout/ovf as a result for exactly the slot
// that sample occupies, NUM_STAGE ce=1 edges after it was accepted.
module decoder_mul_pipe
  import decoder_mul_pkg::*;
#(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int din0_WIDTH  = 18,
  parameter int din1_WIDTH  = 17,
  parameter int dout_WIDTH  = 26,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int SHIFT       = 8,
  parameter int ROUND       = 1,
  parameter int SAT         = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic [din0_WIDTH-1:0]        din0,
  input  logic [din1_WIDTH-1:0]        din1,
  input  logic                         in_vld,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         out_vld,
  output logic                         ovf
);

  localparam int P   = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int A_W = din0_WIDTH + 1;
  localparam int B_W = din1_WIDTH + 1;

  logic signed [A_W-1:0] a_ext, a_s;
  logic signed [B_W-1:0] b_ext, b_s;
  logic signed [P-1:0]   prod_c, prod_s;
  logic [dout_WIDTH-1:0] rs_dout;
  logic                  rs_ovf;

  // One-bit sign or zero extension makes both operands signed for the multiply.
  always_comb begin
    a_ext = (DIN0_SIGNED != 0) ? {din0[din0_WIDTH-1], din0} : {1'b0, din0};
    b_ext = (DIN1_SIGNED != 0) ? {din1[din1_WIDTH-1], din1} : {1'b0, din1};
  end

  if (NUM_STAGE >= 2) begin : g_opreg
    logic signed [A_W-1:0] a_q, a_d;
    logic signed [B_W-1:0] b_q, b_d;
    // Operand register loads only on enabled cycles.
    always_comb begin
      a_d = ce ? a_ext : a_q;
      b_d = ce ? b_ext : b_q;
    end
    // Operand register state.
    always_ff @(posedge clk) begin
      if (reset) begin
        a_q <= '0;
        b_q <= '0;
      end else begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
    assign a_s = a_q;
    assign b_s = b_q;
  end else begin : g_opcomb
    assign a_s = a_ext;
    assign b_s = b_ext;
  end

  assign prod_c = a_s * b_s;

  if (NUM_STAGE >= 3) begin : g_prodreg
    localparam int NP = NUM_STAGE - 2;
    logic signed [P-1:0] prod_q [NP];
    logic signed [P-1:0] prod_d [NP];
    // Product delay line shifts one slot per enabled cycle.
    always_comb begin
      for (int i = 0; i < NP; i++) prod_d[i] = prod_q[i];
      if (ce) begin
        prod_d[0] = prod_c;
        for (int i = 1; i < NP; i++) prod_d[i] = prod_q[i-1];
      end
    end
    // Product register state.
    always_ff @(posedge clk) begin
      for (int i = 0; i < NP; i++) begin
        if (reset) prod_q[i] <= '0;
        else       prod_q[i] <= prod_d[i];
      end
    end
    assign prod_s = prod_q[NP-1];
  end else begin : g_prodcomb
    assign prod_s = prod_c;
  end

  decoder_mul_rndsat #(
    .P          (P),
    .SHIFT      (SHIFT),
    .ROUND      (ROUND),
    .SAT        (SAT),
    .dout_WIDTH (dout_WIDTH)
  ) u_rndsat (
    .prod (prod_s),
    .dout (rs_dout),
    .ovf  (rs_ovf)
  );

  logic [NUM_STAGE-1:0]  vld_q, vld_d;
  logic [dout_WIDTH-1:0] dout_q, dout_d;
  logic                  ovf_q, ovf_d;

  // Valid shift register and output register advance together on ce.
  always_comb begin
    vld_d  = vld_q;
    dout_d = dout_q;
    ovf_d  = ovf_q;
    if (ce) begin
      vld_d[0] = in_vld;
      for (int i = 1; i < NUM_STAGE; i++) vld_d[i] = vld_q[i-1];
      dout_d = rs_dout;
      ovf_d  = rs_ovf;
    end
  end

  // Valid and output register state; reset wins over ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dout    = dout_q;
  assign ovf     = ovf_q;
  assign out_vld = vld_q[NUM_STAGE-1];

endmodule

// File: tb/tb_decoder_mul_pipe.sv
// Bench for decoder_mul_pipe: five instances sharing one stimulus stream.
module tb_decoder_mul_pipe;

  localparam int NDUT = 5;
  localparam int DW   = 26;

  // Instance k: pipeline depth and saturation mode.
  function automatic int ns_of(input int k);
    case (k)
      0:       return 3;
      1:       return 1;
      2:       return 2;
      3:       return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int sat_of(input int k);
    return (k == 4) ? 0 : 1;
  endfunction

  typedef struct {
    logic          vld;
    logic [DW-1:0] d_sat;
    logic [DW-1:0] d_wrap;
    logic          ovf;
  } slot_t;

  logic          clk;
  logic          reset;
  logic          ce;
  logic [17:0]   din0;
  logic [16:0]   din1;
  logic          in_vld;
  logic [DW-1:0] dout_a [NDUT];
  logic          vld_a  [NDUT];
  logic          ovf_a  [NDUT];

  slot_t exp_q[$];
  bit    armed;
  int    errors;
  int    checks;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    decoder_mul_pipe #(
      .ID        (k),
      .NUM_STAGE (ns_of(k)),
      .SAT       (sat_of(k))
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .ce      (ce),
      .din0    (din0),
      .din1    (din1),
      .in_vld  (in_vld),
      .dout    (dout_a[k]),
      .out_vld (vld_a[k]),
      .ovf     (ovf_a[k])
    );
  end

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: exact integer product, round half up, floor divide by 256,
  // then clamp or keep the low 26 bits.
  function automatic slot_t ref_calc(input logic v, input logic [17:0] a, input logic [16:0] b);
    slot_t  s;
    longint av, bv, p, r, hi, lo;
    av = longint'($signed(a));
    bv = longint'(b);
    p  = av * bv + 128;
    r  = p >>> 8;
    hi = (longint'(1) <<< 25) - 1;
    lo = -(longint'(1) <<< 25);
    s.vld    = v;
    s.ovf    = (r > hi) || (r < lo);
    s.d_wrap = r[DW-1:0];
    if (r > hi)      s.d_sat = hi[DW-1:0];
    else if (r < lo) s.d_sat = lo[DW-1:0];
    else             s.d_sat = r[DW-1:0];
    return s;
  endfunction

  // Scoreboard producer: every accepted slot queues its expected result.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      armed = 1'b1;
    end else if (ce) begin
      exp_q.push_back(ref_calc(in_vld, din0, din1));
      if (exp_q.size() > 4) void'(exp_q.pop_front());
    end
  end

  // Monitor: each instance shows the slot accepted ns_of(k) enabled edges ago.
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < NDUT; k++) begin
        logic          ev, eo;
        logic [DW-1:0] ed;
        int            n;
        n  = ns_of(k);
        ev = 1'b0;
        eo = 1'b0;
        ed = '0;
        if (exp_q.size() >= n) begin
          ev = exp_q[exp_q.size() - n].vld;
          eo = exp_q[exp_q.size() - n].ovf;
          ed = (sat_of(k) != 0) ? exp_q[exp_q.size() - n].d_sat : exp_q[exp_q.size() - n].d_wrap;
        end
        checks++;
        if (vld_a[k] !== ev) begin
          errors++;
          $display("FAIL out_vld dut%0d t=%0t got=%b exp=%b", k, $time, vld_a[k], ev);
        end
        checks++;
        if (dout_a[k] !== ed) begin
          errors++;
          $display("FAIL dout dut%0d t=%0t got=%0d exp=%0d", k, $time,
                   $signed(dout_a[k]), $signed(ed));
        end
        checks++;
        if (ovf_a[k] !== eo) begin
          errors++;
          $display("FAIL ovf dut%0d t=%0t got=%b exp=%b", k, $time, ovf_a[k], eo);
        end
      end
    end
  end

  // Driver: apply one cycle of inputs at the falling edge.
  task automatic step(input logic c, input logic v, input logic [17:0] a, input logic [16:0] b);
    ce     = c;
    in_vld = v;
    din0   = a;
    din1   = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, 18'($urandom), 17'($urandom));
  endtask

  function automatic logic [17:0] pick_a();
    case ($urandom_range(0, 7))
      0:       return 18'h1FFFF;
      1:       return 18'h20000;
      default: return 18'($urandom);
    endcase
  endfunction

  function automatic logic [16:0] pick_b();
    case ($urandom_range(0, 7))
      0:       return 17'h1FFFF;
      1:       return 17'd0;
      default: return 17'($urandom);
    endcase
  endfunction

  // Stimulus sequence and final report.
  initial begin
    errors = 0;
    checks = 0;
    armed  = 1'b0;
    reset  = 1'b1;
    ce     = 1'b0;
    in_vld = 1'b0;
    din0   = '0;
    din1   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Small negative times unsigned, then positive and negative overflow.
    step(1'b1, 1'b1, -18'sd3, 17'd1000);
    step(1'b1, 1'b1, 18'd131071, 17'd131071);
    step(1'b1, 1'b1, 18'h20000, 17'd131071);
    idle(5);

    // One sample, then five disabled cycles interleaved with enabled ones.
    step(1'b1, 1'b1, -18'sd3, 17'd1000);
    repeat (5) step(1'b0, 1'b0, 18'($urandom), 17'($urandom));
    step(1'b1, 1'b0, 18'd7, 17'd9);
    step(1'b0, 1'b0, 18'd7, 17'd9);
    idle(5);

    // Two samples in flight, then a one-cycle reset pulse.
    step(1'b1, 1'b1, 18'd131071, 17'd131071);
    step(1'b1, 1'b1, -18'sd3, 17'd1000);
    reset = 1'b1;
    step(1'b1, 1'b0, 18'd5, 17'd5);
    reset = 1'b0;
    idle(6);

    // Four back-to-back random samples.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, pick_a(), pick_b());
    idle(5);

    // Random traffic with random enable gaps and occasional resets.
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, pick_a(), pick_b());
    end
    reset = 1'b0;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_mul_pipe.md
DECODER_MUL_PIPE -- requirements
Module: decoder_mul_pipe

Interface
REQ-001 Parameter ID, default 1; instance tag, no functional effect.
REQ-002 Parameter NUM_STAGE, default 3; pipeline latency in ce-qualified cycles; legal range 1..4.
REQ-003 Parameter din0_WIDTH, default 18; width of operand A.
REQ-004 Parameter din1_WIDTH, default 17; width of operand B.
REQ-005 Parameter dout_WIDTH, default 26; result width.
REQ-006 Parameter DIN0_SIGNED, default 1; 1 means din0 is two's complement, 0 means unsigned.
REQ-007 Parameter DIN1_SIGNED, default 0; same meaning for din1.
REQ-008 Parameter SHIFT, default 8; arithmetic right shift applied to the full product; range 0..(din0_WIDTH+din1_WIDTH-1).
REQ-009 Parameter ROUND, default 1; 1 means round-half-up before the shift, 0 means truncate (floor).
REQ-010 Parameter SAT, default 1; 1 means saturate to dout range, 0 means wrap (keep LSBs).
REQ-011 clk  input  1  sole clock, rising edge.
REQ-012 reset  input  1  synchronous, active-high reset.
REQ-013 ce  input  1  clock enable; all pipeline state advances only when ce=1.
REQ-014 din0  input  din0_WIDTH  operand A.
REQ-015 din1  input  din1_WIDTH  operand B.
REQ-016 in_vld  input  1  operands valid this cycle; sampled only when ce=1.
REQ-017 dout  output  dout_WIDTH  registered result, signed.
REQ-018 out_vld  output  1  dout carries a result.
REQ-019 ovf  output  1  result overflowed the dout range; valid alongside out_vld.

Function
REQ-020 Each operand SHALL be extended by one bit, sign-extended if its SIGNED parameter is 1, zero-extended otherwise; the product SHALL be the exact signed product of width P = din0_WIDTH+din1_WIDTH+2.
REQ-021 With ROUND=1 and SHIFT>0, 2^(SHIFT-1) SHALL be added to the product at P+1 bits before the shift; otherwise no addition.
REQ-022 The shifted value R SHALL be the arithmetic right shift of the (rounded) product by SHIFT.
REQ-023 ovf SHALL be 1 when R lies outside [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1], independent of SAT.
REQ-024 With SAT=1, an out-of-range R SHALL produce the nearest bound; with SAT=0, dout SHALL be R[dout_WIDTH-1:0].
REQ-025 A sample accepted with ce=1 SHALL appear on dout/out_vld after exactly NUM_STAGE further ce=1 rising edges; cycles with ce=0 do not count.
REQ-026 With ce=0, every pipeline register including dout, out_vld and ovf SHALL hold its value.
REQ-027 Throughput SHALL be one sample per ce=1 cycle; back-to-back inputs produce back-to-back outputs.
REQ-028 The valid flag SHALL travel a NUM_STAGE-deep shift register in lockstep with the data.
REQ-029 With in_vld=0, dout SHALL still be computed from din0/din1, but out_vld SHALL be 0 for that slot.
REQ-030 Stage placement: stage 1 registers the extended operands, the final stage registers the round/shift/saturate result, and intermediate stages register the product; with NUM_STAGE=1 only the output register exists.

Reset
REQ-031 reset=1 at a rising edge SHALL clear all valid bits, dout, ovf and data pipeline registers to 0, regardless of ce.
REQ-032 Samples in flight when reset is asserted SHALL be discarded and never produce out_vld.
REQ-033 The first sample accepted in the cycle after reset deasserts SHALL obey REQ-025.

Structure
REQ-034 Package decoder_mul_pkg SHALL hold the product-width and saturation-bound constant functions shared with other decoder arithmetic blocks.
REQ-035 Rounding, shifting, saturation and ovf logic SHALL live in one combinational sub-module, decoder_mul_rndsat; the pipeline registers stay in decoder_mul_pipe.

Verification
REQ-036 The bench SHALL cover: defaults, ce=1, din0=-3, din1=1000, in_vld=1 -> 3 cycles later dout=-12, ovf=0, out_vld=1.
REQ-037 The bench SHALL cover: din0=131071, din1=131071 -> dout=33554431, ovf=1; and with SAT=0, dout is the wrapped LSBs of 67107840 with ovf=1.
REQ-038 The bench SHALL cover: din0=-131072, din1=131071 -> dout=-33554432, ovf=1.
REQ-039 The bench SHALL cover: one valid sample, then ce=0 for 5 cycles after the first edge -> out_vld rises only after the 3rd ce=1 edge and holds through any ce=0 cycles.
REQ-040 The bench SHALL cover: two samples in flight, reset pulsed for 1 cycle -> out_vld=0 and dout=0 on the next edge, and neither sample ever emerges.
REQ-041 The bench SHALL cover: 4 consecutive valid inputs with NUM_STAGE swept 1..4 -> 4 consecutive correct outputs at latency NUM_STAGE, compared against a reference model.
